// File: rtl/alu_seq_core.sv
// alu_seq_core: start-triggered ALU with an iterative shifter and registered result/flags.
// The result is viewed on 8 LEDs, either as one byte of f or as the flag bits.
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH),
  parameter int SEL_W = $clog2(WIDTH/8) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] led_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             of,
  output logic             cf,
  output logic [7:0]       led
);
  localparam int IW = SEL_W > 1 ? SEL_W - 1 : 1;
  localparam int LW = 8 * (1 << IW);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, f_q, f_d, res, shl;
  logic [2:0] op_q, op_d;
  logic [SH_W-1:0] cnt_q, cnt_d, n;
  logic zf_q, zf_d, of_q, of_d, cf_q, cf_d, res_of, res_cf;
  logic [WIDTH:0] sum, diff;
  logic [IW-1:0] idx;
  logic [LW-1:0] f_ext;
  assign n = b_q[SH_W-1:0];
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign shl = {sh_q[WIDTH-2:0], 1'b0};
  always_comb begin
    res = '0;
    res_of = 1'b0;
    res_cf = 1'b0;
    case (op_q)
      3'b000: res = a_q & b_q;
      3'b001: res = a_q | b_q;
      3'b010: res = a_q ^ b_q;
      3'b011: res = ~(a_q | b_q);
      3'b100: begin
        res = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b101: begin
        res = diff[WIDTH-1:0];
        res_cf = diff[WIDTH];
        res_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b110: res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      default: res = a_q;
    endcase
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    f_d = f_q;
    zf_d = zf_q;
    of_d = of_q;
    cf_d = cf_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d = a;
        b_d = b;
        op_d = alu_op;
        state_d = EXEC;
      end
      EXEC: if (op_q == 3'b111 && n != '0) begin
        sh_d = a_q;
        cnt_d = n;
        state_d = SHIFT;
      end else begin
        f_d = res;
        zf_d = res == '0;
        of_d = res_of;
        cf_d = res_cf;
        state_d = DONE;
      end
      SHIFT: begin
        sh_d = shl;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SH_W'(1)) begin
          f_d = shl;
          zf_d = shl == '0;
          of_d = 1'b0;
          cf_d = sh_q[WIDTH-1];
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      f_q <= '0;
      zf_q <= 1'b0;
      of_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      f_q <= f_d;
      zf_q <= zf_d;
      of_q <= of_d;
      cf_q <= cf_d;
    end
  // Byte indices past the top of f land in zero padding.
  assign idx = IW'(led_sel);
  assign f_ext = LW'(f_q);
  assign led = led_sel[SEL_W-1] ? {5'b0, cf_q, of_q, zf_q} : f_ext[{idx, 3'b000} +: 8];
  assign busy = state_q == EXEC || state_q == SHIFT;
  assign done = state_q == DONE;
  assign f = f_q;
  assign zf = zf_q;
  assign of = of_q;
  assign cf = cf_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed vectors with hand-computed results for alu_seq_core (WIDTH=32).
module tb_alu_seq_core;
  localparam logic [2:0] AND = 3'd0, OR = 3'd1, XOR = 3'd2, NOR = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, SLT = 3'd6, SLL = 3'd7;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] alu_op = '0, led_sel = '0;
  logic [31:0] a = '0, b = '0, f;
  logic busy, done, zf, of, cf;
  logic [7:0] led;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b, f;
    logic zf, of, cf;
    int lat;
  } vec_t;
  vec_t v[17];
  alu_seq_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .led_sel(led_sel), .busy(busy), .done(done), .f(f), .zf(zf), .of(of), .cf(cf), .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] ai, input logic [31:0] bi, output int lat);
    @(negedge clk);
    start = 1'b1;
    alu_op = op;
    a = ai;
    b = bi;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      chk("busy_run", busy, 1);
      @(negedge clk);
      lat++;
    end
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
  endtask
  initial begin
    int lat, pulses, bcyc;
    v[0]  = '{ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
    v[1]  = '{SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v[2]  = '{SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1};
    v[3]  = '{SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    v[4]  = '{SLL, 32'h80000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, 2};
    v[5]  = '{SLL, 32'h80000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0, 5};
    v[6]  = '{SLL, 32'h80000001, 32'h00000000, 32'h80000001, 1'b0, 1'b0, 1'b0, 1};
    v[7]  = '{AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
    v[8]  = '{OR,  32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v[9]  = '{XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0, 1};
    v[10] = '{NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
    v[11] = '{ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1};
    v[12] = '{SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    v[13] = '{SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v[14] = '{SLL, 32'hFFFFFFFF, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b1, 32};
    v[15] = '{SLL, 32'h00000001, 32'hFFFFFF25, 32'h00000020, 1'b0, 1'b0, 1'b0, 6};
    v[16] = '{ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1};
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_f", f, 0);
    chk("rst_flags", {zf, of, cf}, 0);
    chk("rst_led", led, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run(v[i].op, v[i].a, v[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_f", i), f, v[i].f);
      chk($sformatf("v%0d_flags", i), {zf, of, cf}, {v[i].zf, v[i].of, v[i].cf});
    end
    // start held through SHIFT and DONE, operands changed mid-run: one pulse only
    @(negedge clk);
    start = 1'b1;
    alu_op = SLL;
    a = 32'h80000001;
    b = 32'h4;
    @(negedge clk);
    a = 32'hFFFFFFFF;
    b = 32'h1;
    alu_op = ADD;
    pulses = 0;
    bcyc = 0;
    for (int i = 0; i < 6; i++) begin
      pulses += int'(done);
      bcyc += int'(busy);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(done);
      bcyc += int'(busy);
      @(negedge clk);
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_busy_cycles", bcyc, 5);
    chk("ign_f", f, 32'h00000010);
    // held start in IDLE re-triggers every 3 cycles
    start = 1'b1;
    alu_op = ADD;
    a = 32'd2;
    b = 32'd3;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      pulses += int'(done);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_f", f, 32'd5);
    // LED view of f=12345678 with of=1 cf=0
    run(SUB, 32'h80000000, 32'h6DCBA988, lat);
    chk("led_src_f", f, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] exp_led[5];
      exp_led = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h02};
      led_sel = 3'(i);
      #1;
      chk($sformatf("led_sel%0d", i), led, exp_led[i]);
    end
    // async reset mid-SHIFT
    @(negedge clk);
    start = 1'b1;
    alu_op = SLL;
    a = 32'h1;
    b = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_f", f, 0);
    chk("arst_flags", {zf, of, cf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(ADD, 32'd2, 32'd3, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_f", f, 32'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
